// File: rtl/ws2812_pkg.sv
// Shared types and constants for the Adalight-to-WS2812 frame loader.
// Holds the parser state encoding, header bytes and the driver colour order.
package ws2812_pkg;

    typedef enum logic [3:0] {
        S_A,
        S_D,
        S_A2,
        S_HI,
        S_LO,
        S_CHK,
        S_R,
        S_G,
        S_B
    } state_t;

    localparam logic [7:0] HDR_A   = 8'h41;
    localparam logic [7:0] HDR_D   = 8'h64;
    localparam logic [7:0] HDR_A2  = 8'h61;
    localparam logic [7:0] CHK_KEY = 8'h55;

    // The driver shifts green first, so the packed word is {G,R,B}.
    function automatic logic [23:0] pack_grb(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812_idle_timer.sv
// Idle watchdog for the frame loader: expires after T_IDLE cycles without a kick.
// Held cleared while disabled, so it only runs while a frame is in progress.
module ws2812_idle_timer #(
    parameter int T_IDLE = 12000
) (
    input  logic clk,
    input  logic reset,
    input  logic kick,
    input  logic enable,
    output logic expire
);

    localparam int            CW   = (T_IDLE > 1) ? $clog2(T_IDLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(T_IDLE - 1);

    logic [CW-1:0] count;

    // A kick in the expiry cycle suppresses the expiry: the byte wins.
    assign expire = enable && !kick && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || !enable || kick || expire) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/ws2812_frame_loader.sv
// Parses an Adalight serial byte stream and issues one GRB write per LED
// to the WS2812 output driver, with header checksum and idle-abort handling.
module ws2812_frame_loader #(
    parameter int NUM_LEDS = 8,
    parameter int T_IDLE   = 12000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        write,
    output logic        frame_done,
    output logic        hdr_error
);
    import ws2812_pkg::*;

    localparam logic [16:0] LED_LIMIT = 17'(NUM_LEDS);

    state_t      state, state_next;
    logic [7:0]  hi, hi_next;
    logic [7:0]  lo, lo_next;
    logic [7:0]  r, r_next;
    logic [7:0]  g, g_next;
    logic [16:0] total, total_next;
    logic [15:0] led_idx, led_idx_next;
    logic [23:0] rgb_next;
    logic [7:0]  led_num_next;
    logic        write_next;
    logic        frame_done_next;
    logic        hdr_error_next;
    logic        expire;

    ws2812_idle_timer #(
        .T_IDLE (T_IDLE)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .kick   (rx_valid),
        .enable (state != S_A),
        .expire (expire)
    );

    always_comb begin
        state_next      = state;
        hi_next         = hi;
        lo_next         = lo;
        r_next          = r;
        g_next          = g;
        total_next      = total;
        led_idx_next    = led_idx;
        rgb_next        = rgb_data;
        led_num_next    = led_num;
        write_next      = 1'b0;
        frame_done_next = 1'b0;
        hdr_error_next  = 1'b0;

        if (rx_valid) begin
            case (state)
                S_A: begin
                    if (rx_data == HDR_A) state_next = S_D;
                end
                S_D: begin
                    if (rx_data == HDR_D)      state_next = S_A2;
                    else if (rx_data == HDR_A) state_next = S_D;
                    else                       state_next = S_A;
                end
                S_A2: begin
                    if (rx_data == HDR_A2)     state_next = S_HI;
                    else if (rx_data == HDR_A) state_next = S_D;
                    else                       state_next = S_A;
                end
                S_HI: begin
                    hi_next    = rx_data;
                    state_next = S_LO;
                end
                S_LO: begin
                    lo_next    = rx_data;
                    state_next = S_CHK;
                end
                S_CHK: begin
                    if (rx_data == (hi ^ lo ^ CHK_KEY)) begin
                        total_next   = {1'b0, hi, lo} + 17'd1;
                        led_idx_next = '0;
                        state_next   = S_R;
                    end else begin
                        hdr_error_next = 1'b1;
                        state_next     = S_A;
                    end
                end
                S_R: begin
                    r_next     = rx_data;
                    state_next = S_G;
                end
                S_G: begin
                    g_next     = rx_data;
                    state_next = S_B;
                end
                S_B: begin
                    // LEDs beyond the driver length are parsed but dropped.
                    if ({1'b0, led_idx} < LED_LIMIT) begin
                        write_next   = 1'b1;
                        rgb_next     = pack_grb(r, g, rx_data);
                        led_num_next = led_idx[7:0];
                    end
                    led_idx_next = led_idx + 16'd1;
                    if (({1'b0, led_idx} + 17'd1) == total) begin
                        frame_done_next = 1'b1;
                        state_next      = S_A;
                    end else begin
                        state_next = S_R;
                    end
                end
                default: state_next = S_A;
            endcase
        end else if (expire) begin
            state_next = S_A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_A;
            total      <= '0;
            led_idx    <= '0;
            rgb_data   <= '0;
            led_num    <= '0;
            write      <= 1'b0;
            frame_done <= 1'b0;
            hdr_error  <= 1'b0;
        end else begin
            state      <= state_next;
            total      <= total_next;
            led_idx    <= led_idx_next;
            rgb_data   <= rgb_next;
            led_num    <= led_num_next;
            write      <= write_next;
            frame_done <= frame_done_next;
            hdr_error  <= hdr_error_next;
        end
        hi <= hi_next;
        lo <= lo_next;
        r  <= r_next;
        g  <= g_next;
    end

endmodule

// File: tb/tb_ws2812_frame_loader.sv
// Bench for ws2812_frame_loader: directed Adalight scenarios plus random frames,
// checked cycle by cycle against a byte-stream reference parser.
module tb_ws2812_frame_loader;

    localparam int NUM_LEDS = 8;
    localparam int T_IDLE   = 100;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        write;
    logic        frame_done;
    logic        hdr_error;

    ws2812_frame_loader #(
        .NUM_LEDS (NUM_LEDS),
        .T_IDLE   (T_IDLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rgb_data   (rgb_data),
        .led_num    (led_num),
        .write      (write),
        .frame_done (frame_done),
        .hdr_error  (hdr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference parser: header progress as a count of bytes accepted (0..5),
    // payload progress as a flat byte position within the frame.
    int          hdr_pos;
    bit          in_pay;
    int          pay_pos;
    int          total_leds;
    int          idle_run;
    logic [7:0]  m_hi, m_lo, m_r, m_g;
    logic        exp_write, exp_fd, exp_he;
    logic [23:0] exp_rgb;
    logic [7:0]  exp_led;

    task automatic model_reset();
        hdr_pos = 0; in_pay = 0; pay_pos = 0; total_leds = 0; idle_run = 0;
        exp_write = 0; exp_fd = 0; exp_he = 0; exp_rgb = '0; exp_led = '0;
    endtask

    task automatic model_step(input logic rst, input logic v, input logic [7:0] d);
        int led;
        exp_write = 0; exp_fd = 0; exp_he = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!v) begin
            idle_run++;
            if (idle_run >= T_IDLE) begin
                in_pay  = 0;
                hdr_pos = 0;
            end
            return;
        end
        idle_run = 0;
        if (in_pay) begin
            case (pay_pos % 3)
                0: m_r = d;
                1: m_g = d;
                default: begin
                    led = pay_pos / 3;
                    if (led < NUM_LEDS) begin
                        exp_write = 1;
                        exp_rgb   = {m_g, m_r, d};
                        exp_led   = led[7:0];
                    end
                end
            endcase
            pay_pos++;
            if (pay_pos == 3 * total_leds) begin
                exp_fd  = 1;
                in_pay  = 0;
                hdr_pos = 0;
            end
        end else begin
            case (hdr_pos)
                0: if (d == 8'h41) hdr_pos = 1;
                1: hdr_pos = (d == 8'h64) ? 2 : ((d == 8'h41) ? 1 : 0);
                2: hdr_pos = (d == 8'h61) ? 3 : ((d == 8'h41) ? 1 : 0);
                3: begin m_hi = d; hdr_pos = 4; end
                4: begin m_lo = d; hdr_pos = 5; end
                default: begin
                    hdr_pos = 0;
                    if (d == (m_hi ^ m_lo ^ 8'h55)) begin
                        total_leds = int'(m_hi) * 256 + int'(m_lo) + 1;
                        in_pay     = 1;
                        pay_pos    = 0;
                    end else begin
                        exp_he = 1;
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("write",      32'(write),      32'(exp_write));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        chk("hdr_error",  32'(hdr_error),  32'(exp_he));
        chk("rgb_data",   32'(rgb_data),   32'(exp_rgb));
        chk("led_num",    32'(led_num),    32'(exp_led));
    endtask

    // One clock: drive inputs, advance the model, sample just after the edge.
    task automatic step(input logic rst, input logic v, input logic [7:0] d);
        reset    = rst;
        rx_valid = v;
        rx_data  = v ? d : $urandom_range(0, 255);
        model_step(rst, v, d);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rx_valid = 1'b0;
        check_outputs();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_list(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic send_header(input logic [15:0] count, input bit good);
        logic [7:0] c;
        c = count[15:8] ^ count[7:0] ^ 8'h55;
        if (!good) c = c ^ 8'h01;
        send_list('{8'h41, 8'h64, 8'h61, count[15:8], count[7:0], c});
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs();

        // Three-LED frame
        send_list('{8'h41, 8'h64, 8'h61, 8'h00, 8'h02, 8'h57});
        send_list('{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90});
        idle(2);

        // Bad checksum, then a resync stream with a doubled 'A'
        send_list('{8'h41, 8'h64, 8'h61, 8'h00, 8'h02, 8'h00});
        idle(1);
        send_list('{8'h41, 8'h41, 8'h64, 8'h61, 8'h00, 8'h00, 8'h55, 8'h01, 8'h02, 8'h03});

        // Oversize frame, next header immediately after frame_done
        send_header(16'h0009, 1'b1);
        for (int i = 0; i < 30; i++) send(8'(i * 7 + 3));
        send_header(16'h0000, 1'b1);
        send_list('{8'hAA, 8'hBB, 8'hCC});
        idle(2);

        // Idle abort after R,G, then a fresh frame
        send_header(16'h0001, 1'b1);
        send_list('{8'h11, 8'h22});
        idle(T_IDLE);
        send_header(16'h0000, 1'b1);
        send_list('{8'h33, 8'h44, 8'h55});

        // Byte arriving on the expiry cycle wins
        send_header(16'h0000, 1'b1);
        send(8'h66);
        idle(T_IDLE - 1);
        send(8'h77);
        send(8'h88);
        idle(2);

        // Reset mid-frame after the G byte
        send_header(16'h0001, 1'b1);
        send_list('{8'h12, 8'h34});
        step(1'b1, 1'b0, 8'h00);
        send(8'h56);
        idle(2);

        // Randomized frames with gaps, bad checksums, garbage and truncation
        for (int f = 0; f < 40; f++) begin
            int kind;
            int cnt;
            kind = $urandom_range(0, 9);
            cnt  = $urandom_range(0, 11);
            if (kind == 2) for (int j = 0; j < 3; j++) send(8'($urandom_range(0, 255)));
            send_header(16'(cnt), kind != 0);
            if (kind != 0) begin
                for (int j = 0; j < 3 * (cnt + 1); j++) begin
                    if (kind == 1 && j == 3 * (cnt + 1) / 2) begin
                        idle(T_IDLE + $urandom_range(0, 3));
                        break;
                    end
                    send(8'($urandom_range(0, 255)));
                    idle($urandom_range(0, 2));
                end
            end
            idle($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
